// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces two coin-slot switches into one-cycle I/J pulses with jam detection.
// Optional tally counters are enabled with the COIN_TALLY_EN macro.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic coin_i_raw,
  input  logic coin_j_raw,
`ifdef COIN_TALLY_EN
  input  logic tally_clr,
  output logic [7:0] tally_i,
  output logic [7:0] tally_j,
`endif
  output logic I,
  output logic J,
  output logic jam,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, DEBOUNCE, PULSE, RELEASE, JAM} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state, state_n;
  logic [1:0] sync_i, sync_j;
  logic si, sj, sel, sel_n, sel_in, i_n, j_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  assign si = sync_i[1];
  assign sj = sync_j[1];
  assign sel_in = sel ? sj : si;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_i <= '0;
      sync_j <= '0;
    end else begin
      sync_i <= {sync_i[0], coin_i_raw};
      sync_j <= {sync_j[0], coin_j_raw};
    end
  end
  always_comb begin
    state_n = state;
    sel_n = sel;
    cnt_n = cnt;
    i_n = 1'b0;
    j_n = 1'b0;
    case (state)
      IDLE:
        if (si && sj) begin
          state_n = JAM;
          cnt_n = '0;
        end else if (si ^ sj) begin
          state_n = DEBOUNCE;
          sel_n = sj;
          cnt_n = CNT_W'(1);
        end
      DEBOUNCE:
        if (si && sj) begin
          state_n = JAM;
          cnt_n = '0;
        end else if (!sel_in) begin
          state_n = IDLE;
          cnt_n = '0;
        end else if (cnt == LAST) begin
          state_n = PULSE;
          i_n = !sel;
          j_n = sel;
        end else cnt_n = cnt + 1'b1;
      PULSE: begin
        state_n = RELEASE;
        cnt_n = '0;
      end
      RELEASE:
        if (si && sj) begin
          state_n = JAM;
          cnt_n = '0;
        end else if (si || sj) cnt_n = '0;
        else if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      JAM:
        if (si || sj) cnt_n = '0;
        else if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  // Outputs are registered copies of the next-state decode, so they change on the same edge as state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel <= 1'b0;
      cnt <= '0;
      I <= 1'b0;
      J <= 1'b0;
      jam <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      cnt <= cnt_n;
      I <= i_n;
      J <= j_n;
      jam <= state_n == JAM;
      busy <= state_n != IDLE;
    end
  end
`ifdef COIN_TALLY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tally_i <= '0;
      tally_j <= '0;
    end else if (tally_clr) begin
      tally_i <= '0;
      tally_j <= '0;
    end else begin
      if (i_n && tally_i != 8'hff) tally_i <= tally_i + 1'b1;
      if (j_n && tally_j != 8'hff) tally_j <= tally_j + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: table-driven directed vectors plus hand-written multi-cycle sequences for coin_acceptor.
module tb_coin_acceptor;
  logic clk = 1'b0, reset = 1'b1, coin_i_raw = 1'b0, coin_j_raw = 1'b0;
  logic I, J, jam, busy;
  int vectors = 0, miscompares = 0;
`ifdef COIN_TALLY_EN
  logic tally_clr = 1'b0;
  logic [7:0] tally_i, tally_j;
`endif
  coin_acceptor #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .coin_i_raw(coin_i_raw),
    .coin_j_raw(coin_j_raw),
`ifdef COIN_TALLY_EN
    .tally_clr(tally_clr),
    .tally_i(tally_i),
    .tally_j(tally_j),
`endif
    .I(I),
    .J(J),
    .jam(jam),
    .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic ci, cj;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[$];
  task automatic seg(input logic ci, input logic cj, input int n, input logic [3:0] exp);
    for (int k = 0; k < n; k++) tbl.push_back('{ci, cj, exp});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (I && J) begin
      miscompares++;
      $display("FAIL inv_ij: I=%0b J=%0b both high at %0t", I, J, $time);
    end
    if ((I || J) && jam) begin
      miscompares++;
      $display("FAIL inv_jam: pulse I=%0b J=%0b with jam=%0b at %0t", I, J, jam, $time);
    end
  end
  task automatic coin(input logic sel_j, input int hold);
    coin_i_raw = !sel_j;
    coin_j_raw = sel_j;
    repeat (hold) tick();
    coin_i_raw = 1'b0;
    coin_j_raw = 1'b0;
    repeat (10) tick();
  endtask
  initial begin
    int pulses;
    bit done;
    // expected nibble is {I, J, jam, busy} after each edge
    seg(1, 0, 2, 4'b0000); seg(1, 0, 3, 4'b0001); seg(1, 0, 1, 4'b1001);
    seg(1, 0, 4, 4'b0001); seg(0, 0, 5, 4'b0001); seg(0, 0, 3, 4'b0000);
    seg(0, 1, 2, 4'b0000); seg(0, 0, 1, 4'b0001); seg(0, 1, 1, 4'b0001);
    seg(0, 0, 1, 4'b0000); seg(0, 0, 1, 4'b0001); seg(0, 0, 2, 4'b0000);
    seg(1, 1, 2, 4'b0000); seg(1, 1, 6, 4'b0011); seg(0, 0, 5, 4'b0011);
    seg(0, 0, 2, 4'b0000);
    #1;
    for (int c = 0; c < 2; c++) begin
      coin_i_raw = c[0];
      coin_j_raw = !c[0];
      tick();
      chk("reset_outputs", {I, J, jam, busy}, 0);
    end
    coin_i_raw = 1'b0;
    coin_j_raw = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    chk("post_reset_idle", {I, J, jam, busy}, 0);
    for (int r = 0; r < tbl.size(); r++) begin
      coin_i_raw = tbl[r].ci;
      coin_j_raw = tbl[r].cj;
      tick();
      chk($sformatf("vec%0d", r), {I, J, jam, busy}, tbl[r].exp);
    end
    pulses = 0;
    coin_i_raw = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      coin_i_raw = (k <= 6) || (k == 9) || (k == 10);
      tick();
      pulses += I;
    end
    chk("swallow_pulses", pulses, 1);
    chk("swallow_idle", busy, 0);
    coin_i_raw = 1'b1;
    repeat (4) tick();
    chk("midop_busy", busy, 1);
    reset = 1'b1;
    coin_i_raw = 1'b0;
    #1;
    chk("midop_async_busy", busy, 0);
    tick();
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      pulses += I + J;
    end
    chk("midop_no_pulse", pulses, 0);
    coin_j_raw = 1'b1;
    done = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      tick();
      done = J;
    end
    chk("j_pulse_seen", done, 1);
    coin_j_raw = 1'b0;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      done = !busy;
    end
    chk("j_release_idle", done, 1);
`ifdef COIN_TALLY_EN
    tally_clr = 1'b1;
    tick();
    tally_clr = 1'b0;
    coin(0, 8); coin(0, 8); coin(1, 8); coin(0, 8);
    chk("tally_i_3", tally_i, 3);
    chk("tally_j_1", tally_j, 1);
    tally_clr = 1'b1;
    tick();
    tally_clr = 1'b0;
    chk("tally_clr_i", tally_i, 0);
    chk("tally_clr_j", tally_j, 0);
    for (int n = 0; n < 260; n++) coin(0, 6);
    chk("tally_i_sat", tally_i, 255);
    chk("tally_j_zero", tally_j, 0);
`else
    coin(0, 8);
    chk("idle_after_coin", busy, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
